mem_port_arbiter: RTL and testbench

- Arbitrates the single-port unified instruction/data memory between two requesters: the core control FSM (port C) and the program loader/debug port (port L).
- Handles the sub-word store encoding already used by the core (data_length: 00 word, 01 half, 10 byte): generates byte enables, lane-aligns write data, and extracts, sign- or zero-extends read data.
- Sits between the core's memory address/data muxes and the memory macro.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (core C, loader L) in front of a single-port memory macro.
// It aligns sub-word stores to byte lanes and formats sub-word loads.
module mem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [1:0]        c_size,
  input  logic              c_uns,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [1:0]        l_size,
  input  logic              l_uns,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic              l_err,
  output logic [31:0]       l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t            state_reg;
  logic              last_l_reg;
  logic              id_l_reg;
  logic              lat_we_reg;
  logic              lat_uns_reg;
  logic [1:0]        lat_size_reg;
  logic [1:0]        lat_off_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [3:0]        mem_be_reg;
  logic [ADDR_W-3:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              rvalid_reg;
  logic              err_reg;

  logic              c_win;
  logic              l_win;
  logic              sel_we;
  logic              sel_uns;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       shifted;
  logic [31:0]       fmt_rdata;
  logic [31:0]       rdata_vis;

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    return (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b00 && off != 2'b00);
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'b00:   return 4'b1111;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << off;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] size);
    case (size)
      2'b01:   return {2{d[15:0]}};
      2'b10:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  // Tie-break: in round-robin mode C wins only if L was granted last.
  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
    if (rst && state_reg == IDLE) begin
      if (c_req && (ARB_MODE == 1 || !l_req || last_l_reg))
        c_win = 1'b1;
      else if (l_req)
        l_win = 1'b1;
    end
    sel_we    = l_win ? l_we    : c_we;
    sel_uns   = l_win ? l_uns   : c_uns;
    sel_size  = l_win ? l_size  : c_size;
    sel_addr  = l_win ? l_addr  : c_addr;
    sel_wdata = l_win ? l_wdata : c_wdata;
  end

  always_comb begin
    shifted = mem_rdata >> {lat_off_reg, 3'b000};
    case (lat_size_reg)
      2'b01:   fmt_rdata = lat_uns_reg ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   fmt_rdata = lat_uns_reg ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      default: fmt_rdata = shifted;
    endcase
    rdata_vis = (state_reg == RESP && !lat_we_reg) ? fmt_rdata : 32'h0;
  end

  // Error responses surface in the cycle after ERR so every access answers at T+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      last_l_reg    <= 1'b1;
      id_l_reg      <= 1'b0;
      lat_we_reg    <= 1'b0;
      lat_uns_reg   <= 1'b0;
      lat_size_reg  <= 2'b00;
      lat_off_reg   <= 2'b00;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'h0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'h0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'h0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'h0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (c_win || l_win) begin
            id_l_reg     <= l_win;
            last_l_reg   <= l_win;
            lat_we_reg   <= sel_we;
            lat_uns_reg  <= sel_uns;
            lat_size_reg <= sel_size;
            lat_off_reg  <= sel_addr[1:0];
            if (misaligned(sel_addr[1:0], sel_size)) begin
              state_reg <= ERR;
            end else begin
              state_reg     <= ACCESS;
              mem_en_reg    <= 1'b1;
              mem_we_reg    <= sel_we;
              mem_be_reg    <= lane_be(sel_addr[1:0], sel_size);
              mem_addr_reg  <= sel_addr[ADDR_W-1:2];
              mem_wdata_reg <= lane_data(sel_wdata, sel_size);
            end
          end
        end
        ACCESS: begin
          rvalid_reg <= 1'b1;
          state_reg  <= RESP;
        end
        RESP: state_reg <= IDLE;
        ERR: begin
          rvalid_reg <= 1'b1;
          err_reg    <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign c_gnt     = c_win;
  assign l_gnt     = l_win;
  assign c_rvalid  = rvalid_reg && !id_l_reg;
  assign l_rvalid  = rvalid_reg && id_l_reg;
  assign c_err     = err_reg && !id_l_reg;
  assign l_err     = err_reg && id_l_reg;
  assign c_rdata   = (rvalid_reg && !id_l_reg) ? rdata_vis : 32'h0;
  assign l_rdata   = (rvalid_reg && id_l_reg) ? rdata_vis : 32'h0;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 0, l_req = 0, c_we = 0, l_we = 0, c_uns = 0, l_uns = 0;
  logic [11:0] c_addr = 0, l_addr = 0;
  logic [1:0]  c_size = 0, l_size = 0;
  logic [31:0] c_wdata = 0, l_wdata = 0, mem_rdata = 0;

  logic        c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, mem_en, mem_we;
  logic [31:0] c_rdata, l_rdata, mem_wdata;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  logic        f_c_gnt, f_l_gnt, f_c_rvalid, f_l_rvalid, f_c_err, f_l_err, f_mem_en, f_mem_we;
  logic [31:0] f_c_rdata, f_l_rdata, f_mem_wdata;
  logic [3:0]  f_mem_be;
  logic [9:0]  f_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int l_f_cnt = 0;
  bit tie_phase = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_uns(c_uns), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_size(l_size), .l_uns(l_uns), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(12), .ARB_MODE(1)) u_fix (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_uns(c_uns), .c_wdata(c_wdata),
    .c_gnt(f_c_gnt), .c_rvalid(f_c_rvalid), .c_err(f_c_err), .c_rdata(f_c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_size(l_size), .l_uns(l_uns), .l_wdata(l_wdata),
    .l_gnt(f_l_gnt), .l_rvalid(f_l_rvalid), .l_err(f_l_err), .l_rdata(f_l_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_be(f_mem_be), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (tie_phase && f_l_gnt) l_f_cnt <= l_f_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access on one port; call with the DUT idle, returns idle.
  task automatic xfer(input bit port_l, input bit we, input logic [11:0] addr,
                      input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                      input logic [31:0] rd, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic [31:0] exp_rd, input bit exp_err);
    if (port_l) begin
      l_req = 1; l_we = we; l_addr = addr; l_size = size; l_uns = uns; l_wdata = wdata;
    end else begin
      c_req = 1; c_we = we; c_addr = addr; c_size = size; c_uns = uns; c_wdata = wdata;
    end
    #1;
    chk("gnt", port_l ? l_gnt : c_gnt, 1);
    chk("other_gnt", port_l ? c_gnt : l_gnt, 0);
    tick;
    c_req = 0; l_req = 0; mem_rdata = rd;
    chk("mem_en", mem_en, !exp_err);
    chk("early_rvalid", c_rvalid | l_rvalid, 0);
    if (!exp_err) begin
      chk("mem_we", mem_we, we);
      chk("mem_be", mem_be, exp_be);
      chk("mem_addr", mem_addr, addr[11:2]);
      if (we) chk("mem_wdata", mem_wdata, exp_wd);
    end
    tick;
    chk("rvalid", port_l ? l_rvalid : c_rvalid, 1);
    chk("err", port_l ? l_err : c_err, exp_err);
    chk("rdata", port_l ? l_rdata : c_rdata, exp_rd);
    chk("other_rvalid", port_l ? c_rvalid : l_rvalid, 0);
    chk("mem_idle", mem_en, 0);
    $display("[TB] txn port=%s we=%0d addr=%h size=%0d rdata=%h err=%0d",
             port_l ? "L" : "C", we, addr, size, port_l ? l_rdata : c_rdata,
             port_l ? l_err : c_err);
    tick;
    mem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    c_req = 1;
    #2;
    chk("rst_gnt", c_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid", c_rvalid | l_rvalid, 0);
    c_req = 0;
    tick;
    rst = 1;
    tick;

    // Tie: round-robin alternates starting with C, fixed priority always C.
    tie_phase = 1;
    c_req = 1; l_req = 1; c_we = 0; l_we = 0; c_size = 0; l_size = 0;
    c_addr = 12'h020; l_addr = 12'h024;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_rr_c", c_gnt, (i % 2) == 0);
      chk("tie_rr_l", l_gnt, (i % 2) == 1);
      chk("tie_fix_c", f_c_gnt, 1);
      tick;
      chk("tie_gnt_busy", c_gnt | l_gnt, 0);
      tick;
      tick;
    end
    c_req = 0; l_req = 0;
    tie_phase = 0;
    chk("fix_l_gnt_cnt", l_f_cnt, 0);
    tick;

    xfer(0, 0, 12'h010, 2'b00, 0, 32'h0,  32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    xfer(0, 1, 12'h013, 2'b10, 0, 32'hA5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        0);
    xfer(0, 0, 12'h012, 2'b10, 0, 32'h0,  32'h00800000, 4'b0100, 32'h0,        32'hFFFFFF80, 0);
    xfer(0, 0, 12'h012, 2'b10, 1, 32'h0,  32'h00800000, 4'b0100, 32'h0,        32'h00000080, 0);
    xfer(0, 0, 12'h002, 2'b01, 0, 32'h0,  32'h80010000, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    xfer(1, 1, 12'h006, 2'b01, 0, 32'h1234, 32'h0,      4'b1100, 32'h12341234, 32'h0,        0);
    xfer(1, 0, 12'h00C, 2'b00, 1, 32'h0,  32'h11223344, 4'b1111, 32'h0,        32'h11223344, 0);
    xfer(1, 0, 12'h00D, 2'b10, 0, 32'h0,  32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 0);
    xfer(1, 0, 12'h001, 2'b01, 0, 32'h0,  32'h12345678, 4'b0000, 32'h0,        32'h0,        1);
    xfer(0, 0, 12'h000, 2'b11, 0, 32'h0,  32'h12345678, 4'b0000, 32'h0,        32'h0,        1);

    // Reset during ACCESS abandons the read; the following tie goes to C.
    c_req = 1; c_we = 0; c_addr = 12'h030; c_size = 2'b00;
    #1;
    chk("rst_mid_gnt", c_gnt, 1);
    tick;
    c_req = 0;
    mem_rdata = 32'hCAFEF00D;
    chk("rst_mid_mem_en", mem_en, 1);
    rst = 0;
    #1;
    chk("rst_mid_drop_en", mem_en, 0);
    chk("rst_mid_drop_be", mem_be, 0);
    tick;
    chk("rst_mid_rvalid", c_rvalid, 0);
    rst = 1;
    tick;
    chk("rst_post_rvalid", c_rvalid, 0);
    c_req = 1; l_req = 1;
    #1;
    chk("rst_tie_c", c_gnt, 1);
    chk("rst_tie_l", l_gnt, 0);
    tick;
    c_req = 0; l_req = 0;
    tick;
    chk("rst_tie_rvalid", c_rvalid, 1);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
